// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and iteration-counter width.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    localparam int unsigned CNT_W = 6;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on operand
// magnitudes, sign fix-up and HI/LO write in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clock,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] rt_q, rt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [W2-1:0]    acc_q, acc_d;

    op_e              in_op;
    logic             in_signed;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    always_comb begin
        in_op     = op_e'(bus.op);
        in_signed = op_is_signed(in_op);
        rs_mag    = (in_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
        rt_mag    = (in_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    end

    // acc holds {partial product} for multiply and {remainder, quotient} for divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [W2-1:0]    step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[W2-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            // remainder stays below the divisor, so the top bit of the difference is the borrow
            if (!div_diff[WIDTH]) begin
                step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    logic             res_signed, rs_neg, rt_neg;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    always_comb begin
        res_signed = op_is_signed(op_q);
        rs_neg     = res_signed & rs_q[WIDTH-1];
        rt_neg     = res_signed & rt_q[WIDTH-1];
        prod       = (rs_neg ^ rt_neg) ? -acc_q : acc_q;
        quo        = (rs_neg ^ rt_neg) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem        = rs_neg ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        if (op_is_div(op_q)) begin
            if (rt_q == '0) begin
                res_hi = rs_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            res_hi = prod[W2-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = in_op;
                    rs_d    = bus.rs_data;
                    rt_d    = bus.rt_data;
                    if (op_is_div(in_op)) begin
                        acc_d  = {{WIDTH{1'b0}}, rs_mag};
                        opnd_d = rt_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, rt_mag};
                        opnd_d = rs_mag;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            rs_q    <= '0;
            rt_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
        end
    end

    // the corrected result is visible during FIX so it lines up with done
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == FIX);
        bus.hi   = (state_q == FIX) ? res_hi : hi_q;
        bus.lo   = (state_q == FIX) ? res_lo : lo_q;
    end

endmodule
